// File: rtl/demux_1_4_stream_if.sv
// Stream bus for the 1-to-4 demultiplexer: one shared input stream, four output lanes,
// plus the round-robin pointer and frame pulse observed by the producer side.
interface demux_1_4_stream_if #(
  parameter int unsigned DATA_W = 8
);
  logic                  mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_W-1:0]     in_data;
  logic [1:0]            in_sel;
  logic [3:0]            out_valid;
  logic [3:0]            out_ready;
  logic [4*DATA_W-1:0]   out_data;
  logic [1:0]            rr_lane;
  logic                  frame_done;

  // Producer/consumer environment side.
  modport master (
    output mode, in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, rr_lane, frame_done
  );

  // Demultiplexer side.
  modport slave (
    input  mode, in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, rr_lane, frame_done
  );
endinterface

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 stream demultiplexer. Each accepted word lands in one lane register,
// chosen by in_sel (mode 0) or by an internal round-robin pointer (mode 1).
module demux_1_4_stream #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  demux_1_4_stream_if.slave   bus
);

  logic [3:0]             valid_q, valid_d;
  logic [3:0][DATA_W-1:0] data_q, data_d;
  logic [1:0]             rr_q, rr_d;
  logic                   frame_q, frame_d;

  logic [1:0]             tgt;
  logic                   in_ready;
  logic                   acc;

  // Target lane and input handshake; only the target lane can stall the input.
  always_comb begin
    tgt      = bus.mode ? rr_q : bus.in_sel;
    in_ready = ~valid_q[tgt] | bus.out_ready[tgt];
    acc      = bus.in_valid & in_ready;
  end

  // Per-lane next state: load wins over drain so a lane sustains one word per cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < 4; i++) begin
      if (acc && (tgt == 2'(i))) begin
        valid_d[i] = 1'b1;
        data_d[i]  = bus.in_data;
      end else if (valid_q[i] && bus.out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  // Pointer advances per accept in mode 1; mode 0 parks it at lane 0.
  always_comb begin
    rr_d    = 2'd0;
    frame_d = 1'b0;
    if (bus.mode) begin
      rr_d    = acc ? rr_q + 2'd1 : rr_q;
      frame_d = acc & (rr_q == 2'd3);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      rr_q    <= 2'd0;
      frame_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rr_q    <= rr_d;
      frame_q <= frame_d;
    end
  end

  // Drive the bus outputs.
  always_comb begin
    bus.in_ready   = in_ready;
    bus.out_valid  = valid_q;
    bus.out_data   = data_q;
    bus.rr_lane    = rr_q;
    bus.frame_done = frame_q;
  end

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Directed bench for demux_1_4_stream with a reference model and accept scoreboard.
module tb_demux_1_4_stream;

  logic clk;
  logic rst;

  demux_1_4_stream_if #(.DATA_W(8)) bus ();

  demux_1_4_stream #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model state.
  logic [3:0]       mv;
  logic [7:0]       mdata [4];
  logic [1:0]       mrr;
  logic             mframe;
  logic [9:0]       sbq [$];   // {lane, data} of each accepted word

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv     = 4'b0000;
    for (int i = 0; i < 4; i++) mdata[i] = 8'h00;
    mrr    = 2'd0;
    mframe = 1'b0;
    sbq.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(mv));
    chk({tag, ".rr_lane"}, 32'(bus.rr_lane), 32'(mrr));
    chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(mframe));
    chk({tag, ".out_data"}, bus.out_data, {mdata[3], mdata[2], mdata[1], mdata[0]});
  endtask

  // One clock of stimulus: drive, check in_ready, clock, advance model, check outputs.
  task automatic step(input string tag, input logic md, input logic iv,
                      input logic [1:0] sel, input logic [7:0] d, input logic [3:0] ordy);
    logic [1:0] t;
    logic       er;
    logic       acc;
    logic [9:0] e;
    bus.mode      = md;
    bus.in_valid  = iv;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
    t   = md ? mrr : sel;
    er  = ~mv[t] | ordy[t];
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(er));
    acc = iv & er;
    if (acc) sbq.push_back({t, d});
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (acc && t == 2'(i)) mv[i] = 1'b1;
      else if (mv[i] && ordy[i]) mv[i] = 1'b0;
    end
    mframe = md & acc & (mrr == 2'd3);
    mrr    = md ? (acc ? mrr + 2'd1 : mrr) : 2'd0;
    #1;
    if (acc) begin
      e = sbq.pop_front();
      mdata[e[9:8]] = e[7:0];
      chk({tag, ".lane_word"}, 32'(bus.out_data[e[9:8]*8 +: 8]), 32'(e[7:0]));
    end
    check_outputs(tag);
  endtask

  int frame_count;

  initial begin
    model_reset();
    rst           = 1'b1;
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 8'h00;
    bus.out_ready = 4'b0000;
    #1;
    check_outputs("reset");
    #11 rst = 1'b0;

    // Explicit routing, all lanes blocked downstream.
    step("route0", 1'b0, 1'b1, 2'd0, 8'hA1, 4'b0000);
    step("route1", 1'b0, 1'b1, 2'd1, 8'hB2, 4'b0000);
    step("route2", 1'b0, 1'b1, 2'd2, 8'hC3, 4'b0000);
    step("route3", 1'b0, 1'b1, 2'd3, 8'hD4, 4'b0000);
    step("full2a", 1'b0, 1'b1, 2'd2, 8'hE5, 4'b0000);
    step("full2b", 1'b0, 1'b1, 2'd2, 8'hE5, 4'b0000);
    step("full2go", 1'b0, 1'b1, 2'd2, 8'hE5, 4'b0100);

    // Backpressure isolation: lane 1 stuck, lane 3 still flows.
    step("drain3", 1'b0, 1'b0, 2'd0, 8'h00, 4'b1000);
    step("iso3", 1'b0, 1'b1, 2'd3, 8'h33, 4'b0000);
    step("stall1a", 1'b0, 1'b1, 2'd1, 8'h55, 4'b0000);
    step("stall1b", 1'b0, 1'b1, 2'd1, 8'h55, 4'b0000);
    step("take1", 1'b0, 1'b1, 2'd1, 8'h55, 4'b0010);

    // Full throughput on lane 0.
    step("drainall", 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);
    for (int i = 0; i < 16; i++) step("thru", 1'b0, 1'b1, 2'd0, 8'(i), 4'b0001);
    step("drainall2", 1'b0, 1'b0, 2'd0, 8'h00, 4'b1111);

    // Round-robin de-interleave.
    frame_count = 0;
    for (int i = 0; i < 8; i++) begin
      step("rr", 1'b1, 1'b1, 2'd3, 8'(8'h10 + i), 4'b1111);
      if (bus.frame_done === 1'b1) frame_count++;
    end
    chk("rr.frame_count", 32'(frame_count), 32'd2);
    chk("rr.end_lane", 32'(bus.rr_lane), 32'd0);

    // Round-robin stall on a full lane 2, then fall back to explicit mode.
    step("drainrr", 1'b1, 1'b0, 2'd0, 8'h00, 4'b1111);
    step("preload2", 1'b0, 1'b1, 2'd2, 8'h2F, 4'b0000);
    step("rrs0", 1'b1, 1'b1, 2'd0, 8'h20, 4'b0000);
    step("rrs1", 1'b1, 1'b1, 2'd0, 8'h21, 4'b0000);
    step("rrs2a", 1'b1, 1'b1, 2'd0, 8'h22, 4'b0000);
    step("rrs2b", 1'b1, 1'b1, 2'd0, 8'h22, 4'b0000);
    chk("rrs.lane", 32'(bus.rr_lane), 32'd2);
    step("tomode0", 1'b0, 1'b0, 2'd0, 8'h00, 4'b0000);

    // Async reset with lanes 0 and 3 holding words.
    step("drain12", 1'b0, 1'b0, 2'd0, 8'h00, 4'b0110);
    step("load3", 1'b0, 1'b1, 2'd3, 8'h77, 4'b0000);
    chk("pre_rst.valid", 32'(bus.out_valid), 32'h9);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #4 rst = 1'b0;
    step("post_rst", 1'b0, 1'b1, 2'd1, 8'h99, 4'b0000);
    step("post_rst_rr", 1'b1, 1'b1, 2'd3, 8'h9A, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux_1_4_stream.md
Name: demux_1_4_stream

Overview:
- Registered 1-to-4 stream demultiplexer with valid/ready handshaking on the input and on each of the four outputs.
- Routes each accepted input word to one output lane. The lane comes either from an explicit 2-bit select or from an internal round-robin lane pointer (TDM de-interleave mode).
- Splits a single shared stream back into four independent lanes for downstream per-lane consumers.

Parameters:
- DATA_W, 8, width of each data word in bits (minimum 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  lane-selection mode: 0 = explicit (in_sel), 1 = round-robin (internal lane pointer).
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  DATA_W  input word.
- in_sel  input  2  target lane; used only when mode=0.
- out_valid  output  4  bit i set: lane i holds a word.
- out_ready  input  4  bit i set: lane i consumer takes the word this cycle.
- out_data  output  4*DATA_W  lane i data in bits [i*DATA_W +: DATA_W].
- rr_lane  output  2  current round-robin lane pointer.
- frame_done  output  1  one-cycle pulse after a lane-3 word is accepted in mode 1.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values while rst is high, applied immediately (not waiting for a clock edge):
  - out_valid = 4'b0000
  - out_data = all zeros
  - rr_lane = 2'd0
  - frame_done = 0
- Target lane: t = (mode ? rr_lane : in_sel). This is combinational from current inputs and state.
- Input ready: in_ready = ~out_valid[t] | out_ready[t]. It is combinational and depends only on lane t; other lanes never stall the input.
- Accept: acc = in_valid & in_ready.
- Lane register behaviour on each rising edge, for each lane i:
  - acc with t == i: out_data[i] <= in_data and out_valid[i] <= 1. Latency is one cycle (word visible the cycle after acceptance).
  - Otherwise, out_valid[i] & out_ready[i]: out_valid[i] <= 0. out_data[i] holds its last value.
  - Otherwise: hold.
- Simultaneous drain and load on the same lane: out_valid stays 1 and the new data replaces the old. Full throughput of one word per cycle on a single lane is sustained while its out_ready is held high.
- Lanes drain independently and concurrently. Up to 4 words can be in flight, one per lane.
- Round-robin lane pointer:
  - Mode 1: rr_lane increments by 1 on every acc and wraps from 3 to 0. It holds when there is no acc.
  - Mode 0: rr_lane is forced to 0 on each edge, so entering mode 1 always starts at lane 0.
  - A mode change never disturbs words already held in the lane registers.
- frame_done <= (mode & acc & (rr_lane == 3)). It is a registered pulse, high for exactly one cycle, and 0 in all other cycles.
- in_sel is ignored in mode 1. out_ready[i] is ignored while out_valid[i] = 0.
- Producer and consumer rules:
  - Input side: in_data, in_sel and mode are required stable while in_valid is high and in_ready is low. in_valid may deassert without acceptance; no word is lost or duplicated.
  - Output side: out_valid[i] never drops until that lane's word has been taken (out_valid[i] & out_ready[i]).
- Reset mid-operation: all held words are discarded, the pointer returns to 0, and no frame_done is produced. The first cycle after reset deassertion behaves as post-reset idle (in_ready = 1).
- X-safety: when in_valid = 0, no state changes other than output drains and the mode-0 pointer clear.

Test Plan:
- Reset then explicit route: mode=0; send 8'hA1 sel 0, 8'hB2 sel 1, 8'hC3 sel 2, 8'hD4 sel 3 with all out_ready=0.
  - Each out_valid bit rises one cycle after its accept, with the matching data.
  - A fifth word with sel=2 sees in_ready=0 until out_ready[2] pulses.
- Backpressure isolation: lane 1 full with out_ready[1]=0; send to lane 3.
  - in_ready=1 and the lane 3 word is delivered.
  - A lane 1 word waits, stalled, with in_data held; it is accepted the cycle out_ready[1]=1, with out_valid[1] remaining 1 and data updating.
- Full throughput: mode=0, sel=0, out_ready[0]=1, in_valid=1 for 16 cycles with data 0..15.
  - out_data[0] shows 0..15 on consecutive cycles with no bubbles.
- Round-robin: mode=1, all out_ready=1, words 0x10..0x17.
  - Lanes receive 0x10/0x14, 0x11/0x15, 0x12/0x16, 0x13/0x17 in lane order 0,1,2,3,0,1,2,3.
  - frame_done pulses exactly twice, each one cycle after acceptance of 0x13 and of 0x17.
  - rr_lane ends at 0.
- Round-robin stall and mode switch:
  - mode=1; after 2 accepts, hold out_ready[2]=0 with lane 2 full. in_ready=0 and rr_lane stays 2.
  - Switch to mode=0: rr_lane=0, and held lane words are unchanged.
- Async reset mid-traffic: assert rst between clock edges with lanes 0 and 3 full.
  - out_valid=0, rr_lane=0 and frame_done=0 immediately, without waiting for an edge.
  - After release, the first word routes correctly.
